parameter_bus_master: RTL

//  Initiator side of the parameter RAM write/read ports. Parses a byte-serial command stream
//  (host link, e.g. UART/USB bridge) into single-word writes (data+mask) and reads on the

---
 rtl/parameter_bus_master_if.sv | 37 +++
 rtl/parameter_bus_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/parameter_bus_master_if.sv
// Byte-serial command/response streams plus parameter RAM write/read ports.
// The master modport is the bus-master side; the slave modport is the host/RAM side.
interface parameter_bus_master_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            cmd_data_in;
  logic                  cmd_valid_in;
  logic                  cmd_ready_out;
  logic [7:0]            rsp_data_out;
  logic                  rsp_valid_out;
  logic                  rsp_ready_in;
  logic [DATA_WIDTH-1:0] wdata_out;
  logic [ADDR_WIDTH-1:0] wadd_out;
  logic [DATA_WIDTH-1:0] wmask_out;
  logic                  wval_out;
  logic                  wen_out;
  logic [DATA_WIDTH-1:0] rdata_in;
  logic [ADDR_WIDTH-1:0] radd_out;
  logic                  rval_in;
  logic                  ren_out;
  logic                  busy_out;

  modport master (
    input  cmd_data_in, cmd_valid_in, rsp_ready_in, rdata_in, rval_in,
    output cmd_ready_out, rsp_data_out, rsp_valid_out,
           wdata_out, wadd_out, wmask_out, wval_out, wen_out,
           radd_out, ren_out, busy_out
  );

  modport slave (
    output cmd_data_in, cmd_valid_in, rsp_ready_in, rdata_in, rval_in,
    input  cmd_ready_out, rsp_data_out, rsp_valid_out,
           wdata_out, wadd_out, wmask_out, wval_out, wen_out,
           radd_out, ren_out, busy_out
  );
endinterface

// File: rtl/parameter_bus_master.sv
// Parses a byte-serial command stream into parameter RAM writes/reads and returns byte responses.
// Optional read timeout is enabled by defining PBM_TIMEOUT_EN.
//
// state       | meaning
// ------------+---------------------------------------------------
// S_IDLE      | waiting for opcode byte
// S_GET_ADDR  | waiting for address byte
// S_GET_DATA  | collecting NB write data bytes, MSB first
// S_GET_MASK  | collecting NB write mask bytes, MSB first
// S_WRITE     | one-cycle write strobe
// S_READ_REQ  | one-cycle read request strobe
// S_READ_WAIT | waiting for rval_in (or timeout)
// S_SEND_HDR  | sending 'D' header of read response
// S_SEND_DATA | sending NB read data bytes, MSB first
// S_SEND_ACK  | sending 'K' write acknowledge
// S_SEND_ERR  | sending 'E' (bad opcode) or 'T' (read timeout)
module parameter_bus_master #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  parameter_bus_master_if.master bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  localparam logic [7:0] OP_W  = 8'h57;
  localparam logic [7:0] OP_R  = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_D = 8'h44;
  localparam logic [7:0] RSP_E = 8'h45;
  localparam logic [7:0] RSP_T = 8'h54;

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 8) begin : g_bad_aw
    $error("ADDR_WIDTH must be 1..8");
  end
  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_dw
    $error("DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_GET_MASK, S_WRITE, S_READ_REQ,
    S_READ_WAIT, S_SEND_HDR, S_SEND_DATA, S_SEND_ACK, S_SEND_ERR
  } state_t;

  state_t state, state_nx;

  logic [7:0]            cmd_byte;
  logic                  cmd_rdy;
  logic                  cmd_acc;
  logic                  rsp_vld;
  logic                  rsp_acc;
  logic [7:0]            rsp_byte;

  logic                  is_wr;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_sr;
  logic [DATA_WIDTH-1:0] mask_sr;
  logic [DATA_WIDTH-1:0] data_nx;
  logic [DATA_WIDTH-1:0] mask_nx;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] wmask_q;
  logic [ADDR_WIDTH-1:0] wadd_q;
  logic [ADDR_WIDTH-1:0] radd_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [7:0]            err_byte;

`ifdef PBM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmr;
`endif

  assign cmd_byte = bus.cmd_data_in;
  assign cmd_acc  = bus.cmd_valid_in & cmd_rdy;
  assign rsp_acc  = rsp_vld & bus.rsp_ready_in;
  assign data_nx  = (data_sr << 8) | DATA_WIDTH'(cmd_byte);
  assign mask_nx  = (mask_sr << 8) | DATA_WIDTH'(cmd_byte);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cmd_rdy  = 1'b0;
    rsp_vld  = 1'b0;
    rsp_byte = 8'h00;
    case (state)
      S_IDLE: begin
        cmd_rdy = 1'b1;
        if (bus.cmd_valid_in) begin
          if (cmd_byte == OP_W || cmd_byte == OP_R) state_nx = S_GET_ADDR;
          else                                      state_nx = S_SEND_ERR;
        end
      end
      S_GET_ADDR: begin
        cmd_rdy = 1'b1;
        if (bus.cmd_valid_in) state_nx = is_wr ? S_GET_DATA : S_READ_REQ;
      end
      S_GET_DATA: begin
        cmd_rdy = 1'b1;
        if (bus.cmd_valid_in && cnt == LAST) state_nx = S_GET_MASK;
      end
      S_GET_MASK: begin
        cmd_rdy = 1'b1;
        if (bus.cmd_valid_in && cnt == LAST) state_nx = S_WRITE;
      end
      S_WRITE:    state_nx = S_SEND_ACK;
      S_READ_REQ: state_nx = S_READ_WAIT;
      S_READ_WAIT: begin
        // rval_in on the terminal timer cycle still completes the read
        if (bus.rval_in) state_nx = S_SEND_HDR;
`ifdef PBM_TIMEOUT_EN
        else if (tmr == '0) state_nx = S_SEND_ERR;
`endif
      end
      S_SEND_HDR: begin
        rsp_vld  = 1'b1;
        rsp_byte = RSP_D;
        if (bus.rsp_ready_in) state_nx = S_SEND_DATA;
      end
      S_SEND_DATA: begin
        rsp_vld  = 1'b1;
        rsp_byte = rdata_q[DATA_WIDTH-1 -: 8];
        if (bus.rsp_ready_in && cnt == LAST) state_nx = S_IDLE;
      end
      S_SEND_ACK: begin
        rsp_vld  = 1'b1;
        rsp_byte = RSP_K;
        if (bus.rsp_ready_in) state_nx = S_IDLE;
      end
      S_SEND_ERR: begin
        rsp_vld  = 1'b1;
        rsp_byte = err_byte;
        if (bus.rsp_ready_in) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Staging registers keep the RAM-facing outputs stable until the strobe cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_wr    <= 1'b0;
      cnt      <= '0;
      addr_q   <= '0;
      data_sr  <= '0;
      mask_sr  <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      wadd_q   <= '0;
      radd_q   <= '0;
      rdata_q  <= '0;
      err_byte <= 8'h00;
`ifdef PBM_TIMEOUT_EN
      tmr      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_acc) begin
            is_wr    <= (cmd_byte == OP_W);
            err_byte <= RSP_E;
            cnt      <= '0;
          end
        end
        S_GET_ADDR: begin
          if (cmd_acc) begin
            addr_q <= cmd_byte[ADDR_WIDTH-1:0];
            if (!is_wr) radd_q <= cmd_byte[ADDR_WIDTH-1:0];
          end
        end
        S_GET_DATA: begin
          if (cmd_acc) begin
            data_sr <= data_nx;
            cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
          end
        end
        S_GET_MASK: begin
          if (cmd_acc) begin
            mask_sr <= mask_nx;
            cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
            if (cnt == LAST) begin
              wdata_q <= data_sr;
              wmask_q <= mask_nx;
              wadd_q  <= addr_q;
            end
          end
        end
        S_READ_REQ: begin
`ifdef PBM_TIMEOUT_EN
          tmr <= TW'(TIMEOUT_CYCLES - 1);
`endif
        end
        S_READ_WAIT: begin
          if (bus.rval_in) rdata_q <= bus.rdata_in;
`ifdef PBM_TIMEOUT_EN
          else if (tmr == '0) err_byte <= RSP_T;
          else tmr <= tmr - 1'b1;
`endif
        end
        S_SEND_HDR: begin
          if (rsp_acc) cnt <= '0;
        end
        S_SEND_DATA: begin
          if (rsp_acc) begin
            rdata_q <= rdata_q << 8;
            cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.cmd_ready_out = cmd_rdy;
    bus.rsp_valid_out = rsp_vld;
    bus.rsp_data_out  = rsp_byte;
    bus.wval_out      = (state == S_WRITE);
    bus.wen_out       = (state == S_WRITE);
    bus.ren_out       = (state == S_READ_REQ);
    bus.busy_out      = (state != S_IDLE);
    bus.wdata_out     = wdata_q;
    bus.wmask_out     = wmask_q;
    bus.wadd_out      = wadd_q;
    bus.radd_out      = radd_q;
  end
endmodule
